// File: rtl/trap_filter_sequencer.sv
// trap_filter_sequencer: k/l/M parameter owner and enable/valid gating for
// the trapezoidal shaping filter of one ADC channel.
//   in : clk, reset (async, active-high), enable, sample_valid,
//        cfg_k/cfg_l/cfg_m, cfg_load
//   out: cfg_busy, cfg_err, filt_k/filt_l/filt_m, filt_clear, filt_en,
//        out_valid, state_o (IDLE=0 CHECK=1 FLUSH=2 SETTLE=3 RUN=4)
module trap_filter_sequencer #(
  parameter int unsigned DELAY_W      = 6,
  parameter int unsigned M_W          = 10,
  parameter int unsigned MAX_DELAY    = 63,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DEF_K        = 4,
  parameter int unsigned DEF_L        = 12,
  parameter int unsigned DEF_M        = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               sample_valid,
  input  logic [DELAY_W-1:0] cfg_k,
  input  logic [DELAY_W-1:0] cfg_l,
  input  logic [M_W-1:0]     cfg_m,
  input  logic               cfg_load,
  output logic               cfg_busy,
  output logic               cfg_err,
  output logic [DELAY_W-1:0] filt_k,
  output logic [DELAY_W-1:0] filt_l,
  output logic [M_W-1:0]     filt_m,
  output logic               filt_clear,
  output logic               filt_en,
  output logic               out_valid,
  output logic [2:0]         state_o
);

  localparam int unsigned SUM_W = DELAY_W + 1;
  localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    FLUSH  = 3'd2,
    SETTLE = 3'd3,
    RUN    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] sh_k_q, sh_k_d, sh_l_q, sh_l_d;
  logic [M_W-1:0]     sh_m_q, sh_m_d;
  logic [DELAY_W-1:0] k_q, k_d, l_q, l_d;
  logic [M_W-1:0]     m_q, m_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               clear_q, clear_d;
  logic               en_q, en_d;
  logic               ov_q, ov_d;
  logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [SUM_W-1:0]   settle_cnt_q, settle_cnt_d;

  logic               load_ok;
  logic [SUM_W-1:0]   sh_sum;
  logic               set_ok;
  logic [SUM_W-1:0]   settle_tgt;

  always_comb begin
    state_d      = state_q;
    sh_k_d       = sh_k_q;
    sh_l_d       = sh_l_q;
    sh_m_d       = sh_m_q;
    k_d          = k_q;
    l_d          = l_q;
    m_d          = m_q;
    err_d        = err_q;
    flush_cnt_d  = flush_cnt_q;
    settle_cnt_d = settle_cnt_q;

    load_ok    = cfg_load && ((state_q == IDLE) || (state_q == RUN));
    sh_sum     = {1'b0, sh_k_q} + {1'b0, sh_l_q};
    set_ok     = (sh_k_q != '0) && (sh_l_q >= sh_k_q) && (sh_sum <= SUM_W'(MAX_DELAY));
    settle_tgt = {1'b0, k_q} + {1'b0, l_q};

    case (state_q)
      IDLE: begin
        if (load_ok) begin
          sh_k_d  = cfg_k;
          sh_l_d  = cfg_l;
          sh_m_d  = cfg_m;
          state_d = CHECK;
        end else if (enable) begin
          flush_cnt_d = '0;
          state_d     = FLUSH;
        end
      end
      CHECK: begin
        if (set_ok) begin
          k_d         = sh_k_q;
          l_d         = sh_l_q;
          m_d         = sh_m_q;
          err_d       = 1'b0;
          flush_cnt_d = '0;
          state_d     = FLUSH;
        end else begin
          err_d   = 1'b1;
          state_d = enable ? RUN : IDLE;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FC_W'(FLUSH_CYCLES - 1)) begin
          settle_cnt_d = '0;
          state_d      = enable ? SETTLE : IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + FC_W'(1);
        end
      end
      SETTLE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (sample_valid) begin
          settle_cnt_d = settle_cnt_q + SUM_W'(1);
          if (settle_cnt_d == settle_tgt) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (load_ok) begin
          sh_k_d  = cfg_k;
          sh_l_d  = cfg_l;
          sh_m_d  = cfg_m;
          state_d = CHECK;
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_o.
    busy_d  = (state_d == CHECK) || (state_d == FLUSH) || (state_d == SETTLE);
    clear_d = (state_d == FLUSH);
    en_d    = (state_d == SETTLE) || (state_d == RUN);
    // A strobe in RUN qualifies next cycle unless enable drop sends us to IDLE;
    // a load accepted the same cycle still lets it through.
    ov_d    = (state_q == RUN) && sample_valid && (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sh_k_q       <= '0;
      sh_l_q       <= '0;
      sh_m_q       <= '0;
      k_q          <= DELAY_W'(DEF_K);
      l_q          <= DELAY_W'(DEF_L);
      m_q          <= M_W'(DEF_M);
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      clear_q      <= 1'b0;
      en_q         <= 1'b0;
      ov_q         <= 1'b0;
      flush_cnt_q  <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      sh_k_q       <= sh_k_d;
      sh_l_q       <= sh_l_d;
      sh_m_q       <= sh_m_d;
      k_q          <= k_d;
      l_q          <= l_d;
      m_q          <= m_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      clear_q      <= clear_d;
      en_q         <= en_d;
      ov_q         <= ov_d;
      flush_cnt_q  <= flush_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign cfg_busy   = busy_q;
  assign cfg_err    = err_q;
  assign filt_k     = k_q;
  assign filt_l     = l_q;
  assign filt_m     = m_q;
  assign filt_clear = clear_q;
  assign filt_en    = en_q;
  assign out_valid  = ov_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_trap_filter_sequencer.sv
module tb_trap_filter_sequencer;

  localparam int unsigned DW   = 6;
  localparam int unsigned MW   = 10;
  localparam int unsigned MAXD = 63;
  localparam int unsigned FC   = 2;
  localparam int unsigned DK   = 4;
  localparam int unsigned DL   = 12;
  localparam int unsigned DM   = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          sample_valid;
  logic [DW-1:0] cfg_k;
  logic [DW-1:0] cfg_l;
  logic [MW-1:0] cfg_m;
  logic          cfg_load;
  logic          cfg_busy;
  logic          cfg_err;
  logic [DW-1:0] filt_k;
  logic [DW-1:0] filt_l;
  logic [MW-1:0] filt_m;
  logic          filt_clear;
  logic          filt_en;
  logic          out_valid;
  logic [2:0]    state_o;

  always #5 clk = ~clk;

  trap_filter_sequencer #(
    .DELAY_W     (DW),
    .M_W         (MW),
    .MAX_DELAY   (MAXD),
    .FLUSH_CYCLES(FC),
    .DEF_K       (DK),
    .DEF_L       (DL),
    .DEF_M       (DM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sample_valid(sample_valid),
    .cfg_k       (cfg_k),
    .cfg_l       (cfg_l),
    .cfg_m       (cfg_m),
    .cfg_load    (cfg_load),
    .cfg_busy    (cfg_busy),
    .cfg_err     (cfg_err),
    .filt_k      (filt_k),
    .filt_l      (filt_l),
    .filt_m      (filt_m),
    .filt_clear  (filt_clear),
    .filt_en     (filt_en),
    .out_valid   (out_valid),
    .state_o     (state_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc      = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode number, countdowns of flush cycles and strobes still owed.
  int unsigned md, fl_left, st_left;
  int unsigned ak, al, am, sk, sl, sm;
  int unsigned err, ov;

  task automatic model_reset();
    md = 0; fl_left = 0; st_left = 0;
    ak = DK; al = DL; am = DM;
    sk = 0; sl = 0; sm = 0;
    err = 0; ov = 0;
  endtask

  task automatic model_step();
    int unsigned new_ov;
    new_ov = (md == 4 && sample_valid && (cfg_load || enable)) ? 1 : 0;
    if ((md == 0 || md == 4) && cfg_load) begin
      sk = 32'(cfg_k); sl = 32'(cfg_l); sm = 32'(cfg_m);
      md = 1;
    end else begin
      case (md)
        0: if (enable) begin md = 2; fl_left = FC; end
        1: begin
          if (sk >= 1 && sl >= sk && sk + sl <= MAXD) begin
            ak = sk; al = sl; am = sm; err = 0;
            md = 2; fl_left = FC;
          end else begin
            err = 1;
            md = enable ? 4 : 0;
          end
        end
        2: begin
          fl_left--;
          if (fl_left == 0) begin
            if (enable) begin md = 3; st_left = ak + al; end
            else md = 0;
          end
        end
        3: begin
          if (!enable) md = 0;
          else if (sample_valid) begin
            st_left--;
            if (st_left == 0) md = 4;
          end
        end
        4: if (!enable) md = 0;
        default: md = 0;
      endcase
    end
    ov = new_ov;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    check_eq("state",  32'(state_o),    md);
    check_eq("busy",   32'(cfg_busy),   (md >= 1 && md <= 3) ? 1 : 0);
    check_eq("err",    32'(cfg_err),    err);
    check_eq("filt_k", 32'(filt_k),     ak);
    check_eq("filt_l", 32'(filt_l),     al);
    check_eq("filt_m", 32'(filt_m),     am);
    check_eq("clear",  32'(filt_clear), (md == 2) ? 1 : 0);
    check_eq("en",     32'(filt_en),    (md == 3 || md == 4) ? 1 : 0);
    check_eq("ovalid", 32'(out_valid),  ov);
    cyc++;
  endtask

  task automatic run(input int unsigned n, input int unsigned period);
    for (int unsigned i = 0; i < n; i++) begin
      cfg_load     = 1'b0;
      sample_valid = (cyc % period == 0);
      step();
    end
  endtask

  task automatic load(input int unsigned k, input int unsigned l, input int unsigned m);
    cfg_load     = 1'b1;
    cfg_k        = DW'(k);
    cfg_l        = DW'(l);
    cfg_m        = MW'(m);
    sample_valid = (cyc % 4 == 0);
    step();
    cfg_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; cfg_load = 1'b0;
    cfg_k = '0; cfg_l = '0; cfg_m = '0;
    model_reset();
    step();
    step();

    // start-up: flush, 16-strobe settle, run
    reset = 1'b0; enable = 1'b1;
    run(100, 4);

    // valid reload from RUN
    load(8, 20, 300);
    run(140, 4);

    // invalid sets: sum too large, l<k, k=0, then recovery
    load(40, 30, 5);   run(10, 4);
    load(5, 3, 1);     run(5, 4);
    load(0, 7, 1);     run(5, 4);
    load(31, 32, 100); run(140, 2);
    load(31, 33, 100); run(5, 2);
    load(7, 7, 50);    run(40, 2);
    load(8, 7, 50);    run(5, 2);
    load(1, 1, 9);     run(10, 2);

    // load ignored in SETTLE, then enable drop mid-SETTLE
    load(4, 12, 256);
    run(8, 4);
    load(9, 9, 9);
    run(6, 4);
    enable = 1'b0;
    run(4, 4);

    // reset during FLUSH, then full restart
    enable = 1'b1;
    run(1, 4);
    reset = 1'b1;
    run(2, 4);
    reset = 1'b0;
    run(100, 4);

    // load and enable drop together in RUN with a strobe
    enable = 1'b0; cfg_load = 1'b1; sample_valid = 1'b1;
    cfg_k = DW'(6); cfg_l = DW'(6); cfg_m = MW'(7);
    step();
    run(10, 4);

    // randomized traffic
    enable = 1'b1;
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      reset        = ($urandom_range(0, 599) == 0);
      sample_valid = ($urandom_range(0, 2) == 0);
      cfg_load     = ($urandom_range(0, 15) == 0);
      cfg_k        = DW'($urandom_range(0, 40));
      cfg_l        = DW'($urandom_range(0, 63));
      cfg_m        = MW'($urandom);
      step();
    end
    reset = 1'b0;
    cfg_load = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
